// File: rtl/mips_mem_pkg.sv
// Shared definitions for the data-memory access stage: state encoding,
// default bus timeout and the value returned for failed loads.
package mips_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } mem_state_e;

    localparam int unsigned TIMEOUT_DEFAULT = 255;
    localparam logic [31:0] ERR_DATA        = 32'h0000_0000;

endpackage

// File: rtl/mem_timeout_ctr.sv
// Counts cycles spent waiting for a bus acknowledge; expired flags the
// point at which the outstanding request must be abandoned.
module mem_timeout_ctr #(
    parameter logic [7:0] TIMEOUT = 8'd255
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expired
);

    logic [7:0] count_q;

    // Clear has priority over enable; no saturation is needed because the
    // owning FSM leaves REQ as soon as the count reaches TIMEOUT.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= 8'd0;
        end else if (clr) begin
            count_q <= 8'd0;
        end else if (en) begin
            count_q <= count_q + 8'd1;
        end
    end

    assign expired = (count_q == TIMEOUT);

endmodule

// File: rtl/mem_access_unit.sv
// Multi-cycle data-memory access stage between the single-cycle datapath
// and a valid/ack memory bus. Stalls the datapath until the access retires
// and flags misaligned or unacknowledged accesses as sticky errors.
//
// state | meaning
// IDLE  | waiting for MemRead/MemWrite; misaligned accesses go straight to DONE
// REQ   | bus_req held with latched address/data until ack or timeout
// DONE  | one un-stalled cycle in which the instruction retires
module mem_access_unit
    import mips_mem_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] ALUResult,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        Stall,
    output logic        bus_req,
    output logic        bus_we,
    output logic [29:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    input  logic        err_clr,
    output logic        err_misalign,
    output logic        err_timeout
);

    localparam logic [7:0] TIMEOUT_W = TIMEOUT[7:0];

    mem_state_e  state_q;
    logic        req_q;
    logic        we_q;
    logic [29:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic        err_mis_q;
    logic        err_to_q;

    logic access;
    logic misaligned;
    logic launch;
    logic set_mis;
    logic set_to;
    logic ctr_en;
    logic ctr_expired;

    assign access     = MemRead | MemWrite;
    assign misaligned = (ALUResult[1:0] != 2'b00);
    assign launch     = (state_q == IDLE) && access && !misaligned;
    assign set_mis    = (state_q == IDLE) && access && misaligned;
    assign set_to     = (state_q == REQ) && !bus_ack && ctr_expired;

    // The counter starts on the launch edge so it reads k in the k-th REQ
    // cycle; abort therefore lands after exactly TIMEOUT request cycles.
    assign ctr_en = launch || ((state_q == REQ) && !bus_ack);

    mem_timeout_ctr #(
        .TIMEOUT (TIMEOUT_W)
    ) u_timeout_ctr (
        .clk     (clk),
        .reset   (reset),
        .clr     (!ctr_en),
        .en      (ctr_en),
        .expired (ctr_expired)
    );

    // Access sequencing FSM with registered bus outputs, load data and sticky errors.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= 30'd0;
            wdata_q   <= 32'd0;
            rdata_q   <= 32'd0;
            err_mis_q <= 1'b0;
            err_to_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (access) begin
                        addr_q  <= ALUResult[31:2];
                        wdata_q <= WriteData;
                        we_q    <= MemWrite;
                        if (misaligned) begin
                            if (!MemWrite) begin
                                rdata_q <= ERR_DATA;
                            end
                            state_q <= DONE;
                        end else begin
                            req_q   <= 1'b1;
                            state_q <= REQ;
                        end
                    end
                end
                REQ: begin
                    if (bus_ack) begin
                        req_q <= 1'b0;
                        if (!we_q) begin
                            rdata_q <= bus_rdata;
                        end
                        state_q <= DONE;
                    end else if (ctr_expired) begin
                        req_q <= 1'b0;
                        if (!we_q) begin
                            rdata_q <= ERR_DATA;
                        end
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase

            // A new error in the same cycle as err_clr stays flagged.
            err_mis_q <= set_mis || (err_mis_q && !err_clr);
            err_to_q  <= set_to  || (err_to_q  && !err_clr);
        end
    end

    assign Stall        = ((state_q == IDLE) && access) || (state_q == REQ);
    assign ReadData     = rdata_q;
    assign bus_req      = req_q;
    assign bus_we       = we_q;
    assign bus_addr     = addr_q;
    assign bus_wdata    = wdata_q;
    assign err_misalign = err_mis_q;
    assign err_timeout  = err_to_q;

endmodule
